// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - RV32I opcode classes, slot and FSM types shared by the hazard scheduler
package hazard_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;

  function automatic logic writes_rd(input logic [6:0] opc);
    return opc inside {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP};
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc);
    return opc inside {JALR, BRANCH, LOAD, STORE, OP_IMM, OP};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return opc inside {BRANCH, STORE, OP};
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding source select for one ID source register
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  output fwd_sel_e   sel
);

  // a load in EX has no result yet; that case is covered by the load-use stall
  logic unused_mem_load;
  assign unused_mem_load = mem_slot.is_load;

  always_comb begin
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (ex_slot.valid && ex_slot.we && !ex_slot.is_load && ex_slot.rd == rs) begin
        sel = FWD_EX;
      end else if (mem_slot.valid && mem_slot.we && mem_slot.rd == rs) begin
        sel = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - 5-stage pipeline hazard controller (forwarding, stalls, flushes, freezes)
// Optional performance counters: define HAZARD_PERF_CNT_EN
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             id_hold,
  output logic             flush_id,
  output logic             ex_bubble,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [6:0] opc;
  logic [4:0] rs1_use, rs2_use;
  slot_t      id_slot, ex_slot, mem_slot, wb_slot;
  state_e     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       pending, pending_nxt;
  logic       hold, flush, bubble, lu_hit;
  fwd_sel_e   sel1, sel2;

  assign opc = id_inst[6:0];
  // unused sources read as x0, which never matches a producer
  assign rs1_use = (id_valid && reads_rs1(opc)) ? id_inst[19:15] : 5'd0;
  assign rs2_use = (id_valid && reads_rs2(opc)) ? id_inst[24:20] : 5'd0;

  // WB is tracked for completeness; the regfile write-first makes it invisible to forwarding
  logic unused_bits;
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12], wb_slot};

  always_comb begin
    id_slot.valid   = id_valid;
    id_slot.rd      = id_inst[11:7];
    id_slot.we      = id_valid && writes_rd(opc) && (id_inst[11:7] != 5'd0);
    id_slot.is_load = id_valid && (opc == LOAD);
  end

  assign lu_hit = ex_slot.valid && ex_slot.we && ex_slot.is_load &&
                  ((rs1_use == ex_slot.rd) || (rs2_use == ex_slot.rd));

  fwd_select u_fwd_rs1 (.rs(rs1_use), .ex_slot(ex_slot), .mem_slot(mem_slot), .sel(sel1));
  fwd_select u_fwd_rs2 (.rs(rs2_use), .ex_slot(ex_slot), .mem_slot(mem_slot), .sel(sel2));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    hold        = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    if (mem_busy) begin
      hold        = 1'b1;
      state_nxt   = MEM_WAIT;
      pending_nxt = pending | ex_redirect;
    end else begin
      pending_nxt = 1'b0;
      case (state)
        LU_STALL: state_nxt = RUN;
        FLUSH: begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (ex_redirect) begin
            cnt_nxt = FLUSH_RELOAD;
          end else begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) state_nxt = RUN;
          end
        end
        default: begin
          // RUN, or the first cycle after a memory freeze, which services a latched redirect
          state_nxt = RUN;
          if (ex_redirect || pending) begin
            flush  = 1'b1;
            bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = FLUSH_RELOAD;
            end
          end else if (lu_hit) begin
            hold      = 1'b1;
            bubble    = 1'b1;
            state_nxt = LU_STALL;
          end
        end
      endcase
    end
  end

  assign pc_hold     = rst_n & hold;
  assign id_hold     = rst_n & hold & ~flush;
  assign flush_id    = rst_n & flush;
  assign ex_bubble   = rst_n & bubble;
  assign fwd_rs1_sel = rst_n ? sel1 : FWD_RF;
  assign fwd_rs2_sel = rst_n ? sel2 : FWD_RF;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= 2'd0;
      pending  <= 1'b0;
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      if (!mem_busy) begin
        ex_slot  <= bubble ? '0 : id_slot;
        mem_slot <= ex_slot;
        wb_slot  <= mem_slot;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_id && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed self-checking bench for hazard_scheduler (FLUSH_CYCLES=2)
module tb_hazard_scheduler;

  localparam logic [31:0] ADDI_X5     = 32'h00100293;
  localparam logic [31:0] ADD_X6_5_5  = 32'h00528333;
  localparam logic [31:0] ADD_X7_5_6  = 32'h006283B3;
  localparam logic [31:0] LW_X5       = 32'h0000A283;
  localparam logic [31:0] LW_X0       = 32'h0000A003;
  localparam logic [31:0] ADDI_X0     = 32'h00500013;
  localparam logic [31:0] ADD_X6_0_0  = 32'h00000333;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_inst;
  logic        id_valid, ex_redirect, mem_busy;
  logic        pc_hold, id_hold, flush_id, ex_bubble;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [15:0] stall_cycles, flush_cycles;
  logic [7:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // {pc_hold, id_hold, flush_id, ex_bubble, fwd_rs1_sel, fwd_rs2_sel}
  assign ctl = {pc_hold, id_hold, flush_id, ex_bubble, fwd_rs1_sel, fwd_rs2_sel};

  hazard_scheduler #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_hold(pc_hold),
    .id_hold(id_hold), .flush_id(flush_id), .ex_bubble(ex_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  task automatic set_in(input logic [31:0] inst, input logic v, input logic redir, input logic busy);
    id_inst = inst; id_valid = v; ex_redirect = redir; mem_busy = busy;
    #2;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drain;
    for (int i = 0; i < 4; i++) begin set_in(32'h0, 1'b0, 1'b0, 1'b0); tick(); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(ADD_X6_5_5, 1'b1, 1'b1, 1'b1);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_comb: got %b want %b", ctl, 8'h00); end
    tick(); tick();
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_held: got %b want %b", ctl, 8'h00); end
    rst_n = 1'b1;
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_release: got %b want %b", ctl, 8'h00); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_fwd_ex;
    set_in(ADDI_X5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0000_00_00) begin errors++; $display("FAIL fwd_producer: got %b want %b", ctl, 8'b0000_00_00); end
    tick();
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0000_01_01) begin errors++; $display("FAIL fwd_ex_both: got %b want %b", ctl, 8'b0000_01_01); end
    tick();
    set_in(ADD_X7_5_6, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0000_10_01) begin errors++; $display("FAIL fwd_mem_ex_mix: got %b want %b", ctl, 8'b0000_10_01); end
    tick();
    set_in(ADD_X7_5_6, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0000_00_00) begin errors++; $display("FAIL fwd_invalid_id: got %b want %b", ctl, 8'b0000_00_00); end
    tick();
    drain();
  endtask

  task automatic test_load_use;
    set_in(LW_X5, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b1101_00_00) begin errors++; $display("FAIL lu_stall: got %b want %b", ctl, 8'b1101_00_00); end
    tick();
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0000_10_10) begin errors++; $display("FAIL lu_after: got %b want %b", ctl, 8'b0000_10_10); end
    tick();
    drain();
  endtask

  task automatic test_x0;
    set_in(ADDI_X0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(ADD_X6_0_0, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL x0_no_fwd: got %b want %b", ctl, 8'h00); end
    tick();
    drain();
    set_in(LW_X0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(ADD_X6_0_0, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL x0_no_lu: got %b want %b", ctl, 8'h00); end
    tick();
    drain();
  endtask

  task automatic test_flush;
    set_in(32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL flush_c1: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL flush_c2: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL flush_done: got %b want %b", ctl, 8'h00); end
    tick();
    set_in(32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL flush_reload_c2: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL flush_reload_c3: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL flush_reload_done: got %b want %b", ctl, 8'h00); end
    tick();
    set_in(LW_X5, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(ADD_X6_5_5, 1'b1, 1'b1, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL redirect_over_lu: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    drain();
  endtask

  task automatic test_mem_busy;
    set_in(ADDI_X5, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(ADD_X6_5_5, 1'b1, (i == 1), 1'b1);
      checks++;
      if (ctl !== 8'b1100_01_01) begin errors++; $display("FAIL busy_c%0d: got %b want %b", i + 1, ctl, 8'b1100_01_01); end
      tick();
    end
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0011_01_01) begin errors++; $display("FAIL busy_pending_flush: got %b want %b", ctl, 8'b0011_01_01); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b0011_00_00) begin errors++; $display("FAIL busy_flush_c2: got %b want %b", ctl, 8'b0011_00_00); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL busy_done: got %b want %b", ctl, 8'h00); end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall;
    set_in(LW_X5, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'b1101_00_00) begin errors++; $display("FAIL rst_pre_stall: got %b want %b", ctl, 8'b1101_00_00); end
    tick();
    rst_n = 1'b0;
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rst_in_lu: got %b want %b", ctl, 8'h00); end
    tick();
    rst_n = 1'b1;
    set_in(ADD_X6_5_5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rst_slots_clear: got %b want %b", ctl, 8'h00); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cycles); end
    checks++; if (flush_cycles !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d want 0", flush_cycles); end
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (stall_cycles !== (PERF ? 16'd2 : 16'd0)) begin errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cycles, PERF ? 2 : 0); end
    checks++; if (flush_cycles !== (PERF ? 16'd1 : 16'd0)) begin errors++; $display("FAIL perf_flush: got %0d want %0d", flush_cycles, PERF ? 1 : 0); end
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_x0();
    test_flush();
    test_mem_busy();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
